// File: rtl/xbar_credit_issuer_pkg.sv
// Shared mpc types for the xbar credit issuer: configuration, index/credit
// types, channel defaults and the issuer FSM encoding.
package mpc_types;

  typedef struct packed {
    logic [31:0] lsqSize;
  } mpc_u_cfg_t;

  typedef struct packed {
    mpc_u_cfg_t u;
  } mpc_cfg_t;

  localparam mpc_cfg_t Cfg = '{u: '{lsqSize: 32'd32}};

  localparam int unsigned LsqIdxW = $clog2(Cfg.u.lsqSize);
  localparam int unsigned RobW    = 6;

  typedef logic [LsqIdxW-1:0] lsqWidth_t;
  typedef logic [RobW-1:0]    robWidth_t;

  localparam int xbar_chan_num = 3;

  localparam int unsigned XbarChanDepthDef  = 8;
  localparam int unsigned XbarRtnThreshDef  = 4;
  localparam int unsigned XbarRtnTimeoutDef = 16;

  typedef enum logic {
    CRDT_INIT,
    CRDT_RUN
  } crdt_iss_state_e;

  function automatic logic is_onehot3(input logic [2:0] v);
    return ($countones(v) == 1);
  endfunction

endpackage

// File: rtl/xbar_credit_issuer_fifo.sv
// Single-channel synchronous FIFO of LSQ indices. The head is read
// combinationally through the registered read pointer, so a pushed entry is
// visible the cycle after its push edge. A pop and a push on a full FIFO in
// the same cycle are both honored.
module crdt_chan_fifo
  import mpc_types::*;
#(
  parameter int unsigned Depth = XbarChanDepthDef
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  lsqWidth_t                    wdata_i,
  output lsqWidth_t                    rdata_o,
  output logic [$clog2(Depth+1)-1:0]   occ_o,
  output logic                         empty_o,
  output logic                         full_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned OccW = $clog2(Depth + 1);

  lsqWidth_t       mem_q [Depth];
  logic [PtrW-1:0] rdPtr_q, rdPtr_d;
  logic [PtrW-1:0] wrPtr_q, wrPtr_d;
  logic [OccW-1:0] occ_q, occ_d;
  logic            doPush, doPop;

  assign empty_o = (occ_q == '0);
  assign full_o  = (occ_q == OccW'(Depth));
  assign occ_o   = occ_q;
  assign rdata_o = empty_o ? '0 : mem_q[rdPtr_q];

  assign doPop  = pop_i & ~empty_o;
  assign doPush = push_i & (~full_o | doPop);

  // Next pointer and occupancy values, wrapping pointers at Depth.
  always_comb begin
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    occ_d   = occ_q;
    if (doPop) begin
      rdPtr_d = (rdPtr_q == PtrW'(Depth - 1)) ? '0 : rdPtr_q + PtrW'(1);
    end
    if (doPush) begin
      wrPtr_d = (wrPtr_q == PtrW'(Depth - 1)) ? '0 : wrPtr_q + PtrW'(1);
    end
    if (doPush && !doPop) begin
      occ_d = occ_q + OccW'(1);
    end else if (doPop && !doPush) begin
      occ_d = occ_q - OccW'(1);
    end
  end

  // Pointer and occupancy registers; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      occ_q   <= '0;
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      occ_q   <= occ_d;
    end
  end

  // Storage write; contents need no reset since occupancy gates the head.
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/xbar_credit_issuer.sv
// Xbar-side credit source for the ISU: advertises each channel's depth after
// reset, buffers accepted requests per channel, and returns freed credits in
// coalesced bursts by threshold or timeout.
module xbar_credit_issuer
  import mpc_types::*;
#(
  parameter int unsigned ChanDepth  = XbarChanDepthDef,
  parameter int unsigned RtnThresh  = XbarRtnThreshDef,
  parameter int unsigned RtnTimeout = XbarRtnTimeoutDef
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  input  logic [2:0]           req_channel_1hot_id,
  input  lsqWidth_t            req_lsq_idx,
  output logic [2:0]           d_head_vld,
  output lsqWidth_t [2:0]      d_head_idx,
  input  logic [2:0]           d_deq,
  output robWidth_t [2:0]      xbar_crdt_rtn,
  output logic                 init_done,
  output logic                 proto_err
);

  localparam int unsigned OccW = $clog2(ChanDepth + 1);
  localparam int unsigned TmrW = $clog2(RtnTimeout + 1);

  crdt_iss_state_e state_q;
  logic            init_done_q;
  logic            proto_err_q;
  robWidth_t       rtn_q [xbar_chan_num];
  robWidth_t       rtn_d [xbar_chan_num];
  robWidth_t       acc_q [xbar_chan_num];
  robWidth_t       acc_d [xbar_chan_num];
  logic [TmrW-1:0] tmr_q [xbar_chan_num];
  logic [TmrW-1:0] tmr_d [xbar_chan_num];
  robWidth_t       accN  [xbar_chan_num];
  logic [OccW-1:0] occ   [xbar_chan_num];

  logic       run;
  logic       chanOk;
  logic       protoErrSet;
  logic [2:0] fifoEmpty, fifoFull;
  logic [2:0] freed, pushSel, ovf, fire;

  assign run    = (state_q == CRDT_RUN);
  assign chanOk = is_onehot3(req_channel_1hot_id);

  assign d_head_vld  = ~fifoEmpty;
  assign init_done   = init_done_q;
  assign proto_err   = proto_err_q;
  assign protoErrSet = req_valid & (~run | ~chanOk | (|ovf));

  for (genvar g = 0; g < xbar_chan_num; g++) begin : gChan
    assign freed[g]   = run & d_deq[g] & ~fifoEmpty[g];
    assign pushSel[g] = run & req_valid & chanOk & req_channel_1hot_id[g] &
                        (~fifoFull[g] | freed[g]);
    assign ovf[g]     = req_channel_1hot_id[g] & (occ[g] == OccW'(ChanDepth)) & ~freed[g];
    assign xbar_crdt_rtn[g] = rtn_q[g];

    crdt_chan_fifo #(
      .Depth (ChanDepth)
    ) uFifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (pushSel[g]),
      .pop_i   (freed[g]),
      .wdata_i (req_lsq_idx),
      .rdata_o (d_head_idx[g]),
      .occ_o   (occ[g]),
      .empty_o (fifoEmpty[g]),
      .full_o  (fifoFull[g])
    );
  end

  // Per-channel coalescing: fold this cycle's freed credit into the
  // accumulator and return the lot on threshold or timeout.
  always_comb begin
    for (int i = 0; i < xbar_chan_num; i++) begin
      accN[i] = acc_q[i] + robWidth_t'(freed[i]);
      fire[i] = (accN[i] >= robWidth_t'(RtnThresh)) |
                ((accN[i] != '0) & (tmr_q[i] == TmrW'(RtnTimeout - 1)));
      if (fire[i]) begin
        rtn_d[i] = accN[i];
        acc_d[i] = '0;
        tmr_d[i] = '0;
      end else begin
        rtn_d[i] = '0;
        acc_d[i] = accN[i];
        tmr_d[i] = (accN[i] != '0) ? tmr_q[i] + TmrW'(1) : '0;
      end
    end
  end

  // Issuer FSM: one INIT cycle advertising full depth, then RUN returning
  // coalesced credits until the next reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CRDT_INIT;
      init_done_q <= 1'b0;
      proto_err_q <= 1'b0;
      for (int i = 0; i < xbar_chan_num; i++) begin
        rtn_q[i] <= '0;
        acc_q[i] <= '0;
        tmr_q[i] <= '0;
      end
    end else begin
      proto_err_q <= proto_err_q | protoErrSet;
      case (state_q)
        CRDT_INIT: begin
          for (int i = 0; i < xbar_chan_num; i++) begin
            rtn_q[i] <= robWidth_t'(ChanDepth);
            acc_q[i] <= '0;
            tmr_q[i] <= '0;
          end
          init_done_q <= 1'b1;
          state_q     <= CRDT_RUN;
        end
        CRDT_RUN: begin
          for (int i = 0; i < xbar_chan_num; i++) begin
            rtn_q[i] <= rtn_d[i];
            acc_q[i] <= acc_d[i];
            tmr_q[i] <= tmr_d[i];
          end
          state_q <= CRDT_RUN;
        end
        default: state_q <= CRDT_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_xbar_credit_issuer.sv
// Self-checking bench for xbar_credit_issuer: a directed vector table, then
// timeout, overflow and random-with-reset sequences, all tracked by a
// behavioural model whose per-cycle expectations flow through a queue.
module tb_xbar_credit_issuer;
  import mpc_types::*;

  localparam int Depth   = 8;
  localparam int Thresh  = 4;
  localparam int Timeout = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid;
  logic [2:0]      req_channel_1hot_id;
  lsqWidth_t       req_lsq_idx;
  logic [2:0]      d_head_vld;
  lsqWidth_t [2:0] d_head_idx;
  logic [2:0]      d_deq;
  robWidth_t [2:0] xbar_crdt_rtn;
  logic            init_done;
  logic            proto_err;

  xbar_credit_issuer #(
    .ChanDepth  (Depth),
    .RtnThresh  (Thresh),
    .RtnTimeout (Timeout)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .req_valid           (req_valid),
    .req_channel_1hot_id (req_channel_1hot_id),
    .req_lsq_idx         (req_lsq_idx),
    .d_head_vld          (d_head_vld),
    .d_head_idx          (d_head_idx),
    .d_deq               (d_deq),
    .xbar_crdt_rtn       (xbar_crdt_rtn),
    .init_done           (init_done),
    .proto_err           (proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         rtn [3];
    logic [2:0] headVld;
    int         headIdx [3];
    bit         initDone;
    bit         protoErr;
  } exp_t;

  typedef struct {
    bit         valid;
    logic [2:0] chan;
    int         idx;
    logic [2:0] deq;
    logic [17:0] expRtn;
    logic [2:0] expVld;
    int         expHead1;
    bit         expErr;
    bit         expInit;
  } vec_t;

  exp_t expQ [$];
  vec_t vecs [12];

  int testsRun    = 0;
  int testsFailed = 0;

  int mQ [3][$];
  int mAcc [3];
  int mTmr [3];
  int mRtn [3];
  int mHeld [3];
  bit mInit;
  bit mErr;
  bit mRun;

  task automatic check(input string name, input int act, input int expv);
    testsRun++;
    if (act != expv) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic modelStep(input bit r, input bit v, input logic [2:0] ch,
                           input int idx, input logic [2:0] deq);
    bit freed [3];
    bit accept;
    int c;
    int accN;
    if (r) begin
      for (int i = 0; i < 3; i++) begin
        mQ[i].delete();
        mAcc[i] = 0; mTmr[i] = 0; mRtn[i] = 0; mHeld[i] = 0;
      end
      mInit = 0; mErr = 0; mRun = 0;
    end else if (!mRun) begin
      for (int i = 0; i < 3; i++) mRtn[i] = Depth;
      mInit = 1; mRun = 1;
      if (v) mErr = 1;
    end else begin
      accept = 0;
      c = ch[0] ? 0 : (ch[1] ? 1 : 2);
      for (int i = 0; i < 3; i++) freed[i] = deq[i] && (mQ[i].size() > 0);
      if (v) begin
        if ($countones(ch) != 1) mErr = 1;
        else if (mQ[c].size() == Depth && !freed[c]) mErr = 1;
        else accept = 1;
      end
      for (int i = 0; i < 3; i++) if (freed[i]) void'(mQ[i].pop_front());
      if (accept) begin
        mQ[c].push_back(idx);
        mHeld[c]--;
      end
      for (int i = 0; i < 3; i++) begin
        accN = mAcc[i] + (freed[i] ? 1 : 0);
        if (accN >= Thresh || (accN != 0 && mTmr[i] == Timeout - 1)) begin
          mRtn[i] = accN; mAcc[i] = 0; mTmr[i] = 0;
        end else begin
          mRtn[i] = 0; mAcc[i] = accN;
          mTmr[i] = (accN != 0) ? mTmr[i] + 1 : 0;
        end
      end
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (expQ.size() == 0) begin
      check("scoreboard underflow", 0, 1);
      return;
    end
    e = expQ.pop_front();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rtn[%0d]", i), int'(xbar_crdt_rtn[i]), e.rtn[i]);
      check($sformatf("head_vld[%0d]", i), int'(d_head_vld[i]), int'(e.headVld[i]));
      check($sformatf("head_idx[%0d]", i), int'(d_head_idx[i]), e.headIdx[i]);
    end
    check("init_done", int'(init_done), int'(e.initDone));
    check("proto_err", int'(proto_err), int'(e.protoErr));
    for (int i = 0; i < 3; i++) mHeld[i] += int'(xbar_crdt_rtn[i]);
    if (mRun) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("conservation ch%0d", i),
              mQ[i].size() + mAcc[i] + mHeld[i], Depth);
      end
    end
  endtask

  task automatic applyStimulus(input bit r, input bit v, input logic [2:0] ch,
                               input int idx, input logic [2:0] deq);
    exp_t e;
    rst                 = r;
    req_valid           = v;
    req_channel_1hot_id = ch;
    req_lsq_idx         = lsqWidth_t'(idx);
    d_deq               = deq;
    modelStep(r, v, ch, idx, deq);
    for (int i = 0; i < 3; i++) begin
      e.rtn[i]     = mRtn[i];
      e.headVld[i] = (mQ[i].size() > 0);
      e.headIdx[i] = (mQ[i].size() > 0) ? mQ[i][0] : 0;
    end
    e.initDone = mInit;
    e.protoErr = mErr;
    expQ.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int hitAt;
    int hitVal;
    int seen;
    int pops;
    int c;
    logic [2:0] ch;
    bit v;

    vecs[0]  = '{valid:0, chan:3'b000, idx:0, deq:3'b000, expRtn:{6'd8, 6'd8, 6'd8}, expVld:3'b000, expHead1:0, expErr:0, expInit:1};
    vecs[1]  = '{valid:1, chan:3'b010, idx:5, deq:3'b000, expRtn:18'd0, expVld:3'b010, expHead1:5, expErr:0, expInit:1};
    vecs[2]  = '{valid:1, chan:3'b010, idx:6, deq:3'b000, expRtn:18'd0, expVld:3'b010, expHead1:5, expErr:0, expInit:1};
    vecs[3]  = '{valid:1, chan:3'b010, idx:7, deq:3'b001, expRtn:18'd0, expVld:3'b010, expHead1:5, expErr:0, expInit:1};
    vecs[4]  = '{valid:1, chan:3'b010, idx:9, deq:3'b000, expRtn:18'd0, expVld:3'b010, expHead1:5, expErr:0, expInit:1};
    vecs[5]  = '{valid:0, chan:3'b000, idx:0, deq:3'b010, expRtn:18'd0, expVld:3'b010, expHead1:6, expErr:0, expInit:1};
    vecs[6]  = '{valid:0, chan:3'b000, idx:0, deq:3'b010, expRtn:18'd0, expVld:3'b010, expHead1:7, expErr:0, expInit:1};
    vecs[7]  = '{valid:0, chan:3'b000, idx:0, deq:3'b010, expRtn:18'd0, expVld:3'b010, expHead1:9, expErr:0, expInit:1};
    vecs[8]  = '{valid:0, chan:3'b000, idx:0, deq:3'b010, expRtn:{6'd0, 6'd4, 6'd0}, expVld:3'b000, expHead1:0, expErr:0, expInit:1};
    vecs[9]  = '{valid:0, chan:3'b000, idx:0, deq:3'b000, expRtn:18'd0, expVld:3'b000, expHead1:0, expErr:0, expInit:1};
    vecs[10] = '{valid:1, chan:3'b011, idx:1, deq:3'b000, expRtn:18'd0, expVld:3'b000, expHead1:0, expErr:1, expInit:1};
    vecs[11] = '{valid:0, chan:3'b000, idx:0, deq:3'b000, expRtn:18'd0, expVld:3'b000, expHead1:0, expErr:1, expInit:1};

    // reset state
    applyStimulus(1, 0, 3'b000, 0, 3'b000);
    applyStimulus(1, 0, 3'b000, 0, 3'b000);

    // directed table: advertise, threshold return, empty pop, bad channel
    for (int k = 0; k < 12; k++) begin
      applyStimulus(0, vecs[k].valid, vecs[k].chan, vecs[k].idx, vecs[k].deq);
      check($sformatf("vec%0d rtn", k), int'(xbar_crdt_rtn), int'(vecs[k].expRtn));
      check($sformatf("vec%0d head_vld", k), int'(d_head_vld), int'(vecs[k].expVld));
      check($sformatf("vec%0d head_idx1", k), int'(d_head_idx[1]), vecs[k].expHead1);
      check($sformatf("vec%0d proto_err", k), int'(proto_err), int'(vecs[k].expErr));
      check($sformatf("vec%0d init_done", k), int'(init_done), int'(vecs[k].expInit));
    end

    // timeout: a lone freed credit on ch0 returns 16 cycles after its pop
    applyStimulus(0, 1, 3'b001, 3, 3'b000);
    applyStimulus(0, 0, 3'b000, 0, 3'b001);
    seen = 1;
    hitAt = -1;
    hitVal = 0;
    if (xbar_crdt_rtn[0] != '0) begin hitAt = seen; hitVal = int'(xbar_crdt_rtn[0]); end
    while (hitAt < 0 && seen < 24) begin
      applyStimulus(0, 0, 3'b000, 0, 3'b000);
      seen++;
      if (xbar_crdt_rtn[0] != '0) begin hitAt = seen; hitVal = int'(xbar_crdt_rtn[0]); end
    end
    check("timeout latency", hitAt, Timeout);
    check("timeout count", hitVal, 1);

    // overflow on ch2: legal push-with-pop when full, then a dropped push
    applyStimulus(1, 0, 3'b000, 0, 3'b000);
    applyStimulus(0, 0, 3'b000, 0, 3'b000);
    for (int k = 0; k < Depth; k++) applyStimulus(0, 1, 3'b100, 10 + k, 3'b000);
    check("full ch2 no error", int'(proto_err), 0);
    applyStimulus(0, 1, 3'b100, 20, 3'b100);
    check("full push+pop accepted", int'(proto_err), 0);
    applyStimulus(0, 1, 3'b100, 21, 3'b000);
    check("overflow sets proto_err", int'(proto_err), 1);
    pops = 0;
    while (d_head_vld[2] && pops < 12) begin
      applyStimulus(0, 0, 3'b000, 0, 3'b100);
      pops++;
    end
    check("ch2 occupancy after overflow", pops, Depth);
    applyStimulus(0, 0, 3'b000, 0, 3'b111);

    // random traffic with a reset pulse in the middle
    applyStimulus(1, 0, 3'b000, 0, 3'b000);
    applyStimulus(0, 0, 3'b000, 0, 3'b000);
    for (int k = 0; k < 240; k++) begin
      if (k == 120 || k == 121) begin
        applyStimulus(1, 0, 3'b000, 0, 3'b000);
      end else if (k == 122) begin
        applyStimulus(0, 0, 3'b000, 0, 3'b000);
        check("readvertise", int'(xbar_crdt_rtn), int'({6'd8, 6'd8, 6'd8}));
        check("readvertise init_done", int'(init_done), 1);
      end else begin
        c  = int'($urandom_range(0, 2));
        ch = 3'b001 << c;
        v  = ($urandom_range(0, 1) == 1) && (mHeld[c] > 0);
        if ($urandom_range(0, 31) == 0) begin
          ch = 3'b110;
          v  = 1;
        end
        applyStimulus(0, v, ch, int'($urandom_range(0, 31)), 3'($urandom_range(0, 7)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/xbar_credit_issuer.md
# xbar_credit_issuer

Sits at the xbar end of the three ISU access channels and acts as the credit source for the ISU credit manager. It advertises each channel's buffer depth as initial credits after reset. It buffers each accepted request's LSQ index in a per-channel FIFO. It returns credits on `xbar_crdt_rtn` as downstream drains entries, coalescing returns by threshold or timeout so credits reach the ISU in bulk.

## Interface
- `Cfg`, `'0`: global mpc configuration; `Cfg.u.lsqSize` sizes LSQ indices.
- `robWidth_t`, `logic`: credit-count type, shared with the ISU credit return port.
- `lsqWidth_t`, `logic`: LSQ index type.
- `ChanDepth`, `8`: per-channel buffer depth, which is also the initial credits per channel. Must be ≥1 and < 2^$bits(robWidth_t).
- `RtnThresh`, `4`: coalesced credits that force a return; range 1..ChanDepth.
- `RtnTimeout`, `16`: cycles a nonzero accumulator may wait before a forced return; must be ≥1.
- `clk` in 1: clock.
- `rst` in 1: **synchronous, active-high reset**. The block uses one clock.
- `req_valid` in 1: an ISU request is entering the xbar this cycle.
- `req_channel_1hot_id` in 3: target channel, one-hot.
- `req_lsq_idx` in lsqWidth_t: LSQ entry of the request.
- `d_head_vld` out 3: channel i FIFO is non-empty.
- `d_head_idx` out lsqWidth_t [2:0]: head LSQ index of each channel.
- `d_deq` in 3: downstream pops the head of channel i.
- `xbar_crdt_rtn` out robWidth_t [2:0]: credits returned to the ISU this cycle, as a count.
- `init_done` out 1: initial credits have been advertised.
- `proto_err` out 1: sticky error; set by overflow, non-one-hot channel, or a request during INIT.

## Operation
- FSM states are INIT and RUN.
  - Reset puts the FSM in INIT.
  - In INIT, the block registers `xbar_crdt_rtn[i] <= ChanDepth` for all i and moves to RUN on the next edge.
  - RUN is held until `rst`.
- Enqueue:
  - When `req_valid` is high with a one-hot channel c in RUN, `req_lsq_idx` is pushed to FIFO c and `occ[c]` increments.
  - Push when `occ[c]==ChanDepth` with no same-cycle pop on c: the request is dropped, `proto_err` is set, and credits are unaffected.
  - Full FIFO with a simultaneous pop on c: the pop is applied first, then the push; legal, `occ` unchanged.
  - Channel not one-hot, or `req_valid` in INIT: the request is dropped and `proto_err` is set.
- Dequeue:
  - `d_deq[i] & d_head_vld[i]` pops FIFO i, decrements `occ[i]`, and frees one credit (`freed[i]=1`).
  - `d_deq[i]` when empty is ignored; it is not an error.
- Coalescing, per channel, in RUN:
  - `acc_n = acc[i] + freed[i]`.
  - Fire when `acc_n >= RtnThresh`, or when `acc_n != 0` and `tmr[i] == RtnTimeout-1`.
  - On fire: `xbar_crdt_rtn[i] <= acc_n`, `acc[i] <= 0`, `tmr[i] <= 0`.
  - Otherwise: `xbar_crdt_rtn[i] <= 0` and `acc[i] <= acc_n`. `tmr[i]` increments while `acc_n != 0` and holds 0 while the accumulator is empty.
- Conservation invariant per channel: `occ + acc + credits held by ISU == ChanDepth`. `acc` never exceeds ChanDepth.
- Channels are fully independent. Simultaneous pushes and pops on different channels are all honored in the same cycle.

## Timing
- Reset values:
  - `xbar_crdt_rtn` = 0, `init_done` = 0, `proto_err` = 0, `d_head_vld` = 0, `d_head_idx` = 0.
  - All `occ`, `acc`, `tmr` and FIFO pointers = 0.
- Initial credits: on the first edge with `rst` low, `xbar_crdt_rtn[i]` becomes ChanDepth for exactly one cycle and `init_done` rises, staying high.
- Request to visibility: a pushed entry appears at `d_head_vld` / `d_head_idx` one cycle after the push edge (FIFO read is registered through the pointer).
- Pop to credit: with RtnThresh=1, credit appears on `xbar_crdt_rtn` on the edge of the pop, so it is visible the following cycle.
- Timeout: a single freed credit with RtnThresh>1 and no further pops is returned RtnTimeout cycles after the pop.
- Reset asserted mid-operation:
  - All buffered entries and unreturned credits are discarded.
  - The block re-enters INIT and re-advertises the full ChanDepth.
  - The ISU credit manager must be reset in the same cycle.

## Structure
- Shared package `mpc_types`:
  - `xbar_chan_num = 3`.
  - Defaults for ChanDepth, RtnThresh and RtnTimeout.
  - The FSM enum `crdt_iss_state_e {CRDT_INIT, CRDT_RUN}`.
- Sub-module `crdt_chan_fifo`: a single-channel sync FIFO of lsqWidth_t, depth ChanDepth, with push/pop/occupancy/empty/full outputs.
  - It is instantiated three times in a generate loop.
  - The coalescing counters live in the top level.

## Test plan
- Reset release: `xbar_crdt_rtn` = {8,8,8} for one cycle, then {0,0,0}; `init_done` = 1.
- RtnThresh=4: push 4 entries on ch1, pop all 4 on consecutive cycles → single `xbar_crdt_rtn[1]` = 4 the cycle after the 4th pop; other channels stay 0.
- RtnThresh=4, RtnTimeout=16: one pop on ch0 → `xbar_crdt_rtn[0]` = 1 exactly 16 cycles later.
- Fill ch2 to 8 entries, push a 9th with no pop → dropped, `proto_err` = 1, `occ[2]` = 8. Repeat with a simultaneous pop → accepted, `proto_err` unchanged.
- Push with `req_channel_1hot_id` = 3'b011 → dropped, `proto_err` = 1. `d_deq` on an empty channel → no credit, no error.
- Random traffic with reset pulsed mid-stream → after release, {8,8,8} is re-advertised. The conservation invariant holds every cycle in a scoreboard.
